// File: rtl/seq_divider_32b.sv
// rtl/seq_divider_32b.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
//
// Purpose: unsigned restoring division with a start/done handshake. An accepted
// request is worked on for WIDTH clocks (one quotient bit each). A zero divisor
// bypasses the iteration and reports div_by_zero on the next cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while ready=1
//   dividend     numerator, captured on the accepting edge
//   divisor      denominator, captured on the accepting edge
//   ready        high in IDLE and DONE; start is accepted when ready & start
//   busy         high while iterating (RUN)
//   done         one-cycle pulse; results valid from this cycle on
//   div_by_zero  qualifies done; held with the results
//   quotient     registered quotient, held until the next done
//   remainder    registered remainder, held until the next done

module seq_divider_32b #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  // The partial remainder is always < D after an iteration, so its top bit is
  // always 0 and only WIDTH bits need storing; the extra bit appears only in
  // the shifted value that feeds the trial subtraction.
  logic [WIDTH-1:0] r_reg;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             div_zero_in;
  logic             last_iter;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_nxt;

  assign ready       = (state != ST_RUN);
  assign busy        = (state == ST_RUN);
  assign done        = (state == ST_DONE);
  assign accept      = ready & start;
  assign div_zero_in = (divisor == '0);
  assign last_iter   = (cnt == CNT_W'(WIDTH - 1));

  // One restoring step: shift {R,Q} left, trial-subtract D, keep on non-negative.
  always_comb begin
    r_sh  = {r_reg, q_reg[WIDTH-1]};
    trial = r_sh - {1'b0, d_reg};
    if (!trial[WIDTH]) begin
      r_nxt = trial[WIDTH-1:0];
      q_nxt = {q_reg[WIDTH-2:0], 1'b1};
    end else begin
      r_nxt = r_sh[WIDTH-1:0];
      q_nxt = {q_reg[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = div_zero_in ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (last_iter) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (start) state_nxt = div_zero_in ? ST_DONE : ST_RUN;
        else       state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      q_reg <= dividend;
      d_reg <= divisor;
      r_reg <= '0;
      cnt   <= '0;
      // Zero divisor: results are published on the accepting edge so they
      // line up with the done pulse in the following cycle.
      if (div_zero_in) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (busy) begin
      q_reg <= q_nxt;
      r_reg <= r_nxt;
      cnt   <= cnt + CNT_W'(1);
      if (last_iter) begin
        quotient    <= q_nxt;
        remainder   <= r_nxt;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_32b.sv
// tb/tb_seq_divider_32b.sv - directed self-checking bench for seq_divider_32b

module tb_seq_divider_32b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        ready;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int checks = 0;
  int fails  = 0;
  int n;
  logic seen_done;

  seq_divider_32b #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns at the falling edge after the accepting edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts rising edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int cnt_o);
    cnt_o = 0;
    while (done !== 1'b1 && cnt_o < 100) begin
      @(negedge clk);
      cnt_o++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 100 / 7
    launch(32'd100, 32'd7);
    chk("100_7_busy", busy, 1);
    chk("100_7_ready", ready, 0);
    wait_done(n);
    chk("100_7_lat", n, 32);
    chk("100_7_q", quotient, 14);
    chk("100_7_r", remainder, 2);
    chk("100_7_dbz", div_by_zero, 0);
    @(negedge clk);
    chk("100_7_pulse", done, 0);
    chk("100_7_idle_ready", ready, 1);

    // extremes
    launch(32'hFFFF_FFFF, 32'd1);
    wait_done(n);
    chk("ff_1_q", quotient, 32'hFFFF_FFFF);
    chk("ff_1_r", remainder, 0);
    launch(32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    chk("80_ff_q", quotient, 0);
    chk("80_ff_r", remainder, 32'h8000_0000);

    // divide by zero, then a normal op clears the flag
    launch(32'd5, 32'd0);
    wait_done(n);
    chk("5_0_lat", n, 0);
    chk("5_0_q", quotient, 32'hFFFF_FFFF);
    chk("5_0_r", remainder, 5);
    chk("5_0_dbz", div_by_zero, 1);
    @(negedge clk);
    chk("5_0_hold_dbz", div_by_zero, 1);
    launch(32'd9, 32'd3);
    wait_done(n);
    chk("9_3_q", quotient, 3);
    chk("9_3_r", remainder, 0);
    chk("9_3_dbz", div_by_zero, 0);

    // start and operand changes during RUN are ignored
    launch(32'd1000, 32'd10);
    repeat (9) @(negedge clk);
    start = 1'b1; dividend = 32'd8; divisor = 32'd2;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dividend = $urandom; divisor = $urandom;
      @(negedge clk);
    end
    wait_done(n);
    chk("1000_10_lat", n + 15, 32);
    chk("1000_10_q", quotient, 100);
    chk("1000_10_r", remainder, 0);
    @(negedge clk);
    chk("1000_10_no_restart", busy, 0);

    // start in the DONE cycle is accepted
    launch(32'd77, 32'd4);
    wait_done(n);
    chk("77_4_q", quotient, 19);
    chk("77_4_r", remainder, 1);
    start = 1'b1; dividend = 32'd50; divisor = 32'd6;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_done_low", done, 0);
    wait_done(n);
    chk("50_6_lat", n, 32);
    chk("50_6_q", quotient, 8);
    chk("50_6_r", remainder, 2);

    // reset mid-RUN aborts with no done
    launch(32'd123456, 32'd789);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_ready", ready, 1);
    chk("arst_q", quotient, 0);
    chk("arst_r", remainder, 0);
    chk("arst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    chk("arst_no_done", seen_done, 0);
    launch(32'd7, 32'd7);
    wait_done(n);
    chk("7_7_lat", n, 32);
    chk("7_7_q", quotient, 1);
    chk("7_7_r", remainder, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
